// File: rtl/intirvx_fetch_sched_pkg.sv
// intirvx_fetch_sched shared types and cpu parameters.
// Optional trap redirect: INTIRVX_FETCH_TRAP_EN.
package intirvx_fetch_sched_pkg;

  localparam int XLEN = 32;
  localparam int ALEN = 32;
  localparam logic [ALEN-1:0] START_PC = 32'h0000_1000;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_JAL,
    SRC_ALU,
    SRC_TRAP
  } pc_src_e;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REDIR
  } fsched_state_e;

  typedef struct packed {
    pc_src_e         src;
    logic [ALEN-1:0] target;
  } pc_pick_t;

endpackage

// File: rtl/intirvx_fetch_sched_arb.sv
// Next-PC source priority pick: trap > ALU jump > JAL > sequential.
// Trap input exists only with INTIRVX_FETCH_TRAP_EN.
module intirvx_fetch_sched_arb
  import intirvx_fetch_sched_pkg::*;
`ifdef INTIRVX_FETCH_TRAP_EN
#(
  parameter logic [ALEN-1:0] TRAP_VEC = 'h100
)
`endif
(
`ifdef INTIRVX_FETCH_TRAP_EN
  input  logic            trap_i,
`endif
  input  logic            alu_i,
  input  logic [ALEN-1:0] alu_addr_i,
  input  logic            jal_i,
  input  logic [ALEN-1:0] jal_addr_i,
  output pc_pick_t        pick_o
);

  // Losers in the same cycle are simply dropped: they are younger.
  always_comb begin
    pick_o.src    = SRC_SEQ;
    pick_o.target = '0;
`ifdef INTIRVX_FETCH_TRAP_EN
    if (trap_i) begin
      pick_o.src    = SRC_TRAP;
      pick_o.target = TRAP_VEC;
    end else
`endif
    if (alu_i) begin
      pick_o.src    = SRC_ALU;
      pick_o.target = alu_addr_i;
    end else if (jal_i) begin
      pick_o.src    = SRC_JAL;
      pick_o.target = jal_addr_i;
    end
  end

endmodule

// File: rtl/intirvx_fetch_sched.sv
// Fetch scheduler: owns fetch PC, epoch and in-flight count.
// Optional trap redirect port: INTIRVX_FETCH_TRAP_EN.
module intirvx_fetch_sched
  import intirvx_fetch_sched_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PC_STEP         = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
`ifdef INTIRVX_FETCH_TRAP_EN
  ,
  parameter logic [ALEN-1:0] TRAP_VEC = 'h100
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_jump_i,
  input  logic [ALEN-1:0]  alu_jump_addr_i,
  input  logic             alu_valid_i,
  output logic             alu_ready_o,
  input  logic             jal_valid_i,
  input  logic [ALEN-1:0]  jal_addr_i,
  output logic             jal_ready_o,
`ifdef INTIRVX_FETCH_TRAP_EN
  input  logic             trap_valid_i,
  output logic             trap_ready_o,
`endif
  output logic [ALEN-1:0]  pc_o,
  output logic             pc_epoch_o,
  output logic             pc_valid_o,
  input  logic             pc_ready_i,
  output logic             flush_ifetch_o,
  input  logic [XLEN-1:0]  resp_inst_i,
  input  logic [ALEN-1:0]  resp_pc_i,
  input  logic             resp_epoch_i,
  input  logic             resp_valid_i,
  output logic             resp_ready_o,
  output logic [XLEN-1:0]  inst_o,
  output logic [ALEN-1:0]  inst_pc_o,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [CNT_W-1:0] outstanding_o
);

  localparam logic [CNT_W-1:0] MAX_C =
    CNT_W'(MAX_OUTSTANDING);

  fsched_state_e    state_q, state_d;
  logic [ALEN-1:0]  pc_q, pc_d;
  logic             epoch_q, epoch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic     accept;
  logic     redirect;
  logic     req_fire;
  logic     resp_fire;
  logic     stale;
  pc_pick_t pick;

  intirvx_fetch_sched_arb
`ifdef INTIRVX_FETCH_TRAP_EN
    #(.TRAP_VEC(TRAP_VEC))
`endif
  u_arb (
`ifdef INTIRVX_FETCH_TRAP_EN
    .trap_i     (accept & trap_valid_i),
`endif
    .alu_i      (accept & alu_valid_i & alu_jump_i),
    .alu_addr_i (alu_jump_addr_i),
    .jal_i      (accept & jal_valid_i),
    .jal_addr_i (jal_addr_i),
    .pick_o     (pick)
  );

  assign redirect  = (pick.src != SRC_SEQ);
  assign req_fire  = pc_valid_o & pc_ready_i;
  assign stale     = resp_valid_i
                   & (resp_epoch_i != epoch_q);
  assign resp_fire = resp_valid_i & resp_ready_o;

  assign resp_ready_o  = inst_ready_i | stale;
  assign inst_valid_o  = resp_valid_i & ~stale;
  assign inst_o        = resp_inst_i;
  assign inst_pc_o     = resp_pc_i;
  assign pc_o          = pc_q;
  assign pc_epoch_o    = epoch_q;
  assign outstanding_o = cnt_q;
  assign alu_ready_o   = accept;
  assign jal_ready_o   = accept;
`ifdef INTIRVX_FETCH_TRAP_EN
  assign trap_ready_o  = accept;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // FSM next state: any accepted redirect spends a cycle in REDIR
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:       state_d = RUN;
      RUN, REDIR: state_d = redirect ? REDIR : RUN;
      default:    state_d = BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    pc_valid_o     = 1'b0;
    flush_ifetch_o = 1'b0;
    accept         = 1'b0;
    unique case (state_q)
      RUN: begin
        pc_valid_o = (cnt_q < MAX_C);
        accept     = 1'b1;
      end
      REDIR: begin
        flush_ifetch_o = 1'b1;
        accept         = 1'b1;
      end
      default: ;
    endcase
  end

  // Next PC, epoch and in-flight count
  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q ^ redirect;
    cnt_d   = cnt_q;
    if (state_q == BOOT)
      pc_d = START_PC;
    else if (redirect)
      pc_d = pick.target;
    else if (req_fire)
      pc_d = pc_q + ALEN'(PC_STEP);
    unique case ({req_fire, resp_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   if (cnt_q != '0)
                 cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  // PC, epoch and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      epoch_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      cnt_q   <= cnt_d;
    end
  end

  // A response with nothing in flight means ifetch lost sync
  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(resp_fire && cnt_q == '0));

endmodule

// File: tb/tb_intirvx_fetch_sched.sv
// Scoreboard bench for intirvx_fetch_sched.
// Trap stimulus only with INTIRVX_FETCH_TRAP_EN.
module tb_intirvx_fetch_sched;
  import intirvx_fetch_sched_pkg::*;

  localparam int MAXO = 4;
  localparam int STEP = 4;
  localparam logic [31:0] TVEC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_jump = 0, alu_valid = 0;
  logic [31:0] alu_addr = '0;
  logic        alu_ready, jal_ready;
  logic        jal_valid = 0;
  logic [31:0] jal_addr = '0;
  logic        trap_valid = 0;
  logic        trap_ready;
  logic [31:0] pc;
  logic        pc_epoch, pc_valid;
  logic        pc_ready = 0;
  logic        flush;
  logic [31:0] resp_inst = '0, resp_pc = '0;
  logic        resp_epoch = 0, resp_valid = 0;
  logic        resp_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_valid;
  logic        inst_ready = 0;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  intirvx_fetch_sched #(
    .MAX_OUTSTANDING(MAXO),
    .PC_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_jump_i(alu_jump),
    .alu_jump_addr_i(alu_addr),
    .alu_valid_i(alu_valid),
    .alu_ready_o(alu_ready),
    .jal_valid_i(jal_valid),
    .jal_addr_i(jal_addr),
    .jal_ready_o(jal_ready),
`ifdef INTIRVX_FETCH_TRAP_EN
    .trap_valid_i(trap_valid),
    .trap_ready_o(trap_ready),
`endif
    .pc_o(pc),
    .pc_epoch_o(pc_epoch),
    .pc_valid_o(pc_valid),
    .pc_ready_i(pc_ready),
    .flush_ifetch_o(flush),
    .resp_inst_i(resp_inst),
    .resp_pc_i(resp_pc),
    .resp_epoch_i(resp_epoch),
    .resp_valid_i(resp_valid),
    .resp_ready_o(resp_ready),
    .inst_o(inst),
    .inst_pc_o(inst_pc),
    .inst_valid_o(inst_valid),
    .inst_ready_i(inst_ready),
    .outstanding_o(outstanding)
  );

`ifndef INTIRVX_FETCH_TRAP_EN
  assign trap_ready = 1'b0;
`endif

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        ep;
    logic        fl;
    logic        rdy;
    logic        rr;
    int          cnt;
  } cyc_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ep;
  } fet_t;

  cyc_t cyc_q[$];
  fet_t inst_q[$];
  fet_t fq[$];

  int total = 0;
  int bad = 0;

  // reference model: 0 boot, 1 run, 2 redirect bubble
  int          m_st = 0;
  logic [31:0] m_pc = '0;
  logic        m_ep = 1'b0;

  int p_rdy = 0, p_resp = 0, p_inst = 0;
  int p_alu = 0, p_jal = 0, p_trap = 0;
  bit f_alu = 0, f_jal = 0, f_trap = 0;
  logic [31:0] f_alu_a = '0, f_jal_a = '0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom_range(0, 7) == 0)
      return 32'hFFFF_FFF4;
    return 32'h2000 + ($urandom_range(0, 1023) << 2);
  endfunction

  task automatic step(input bit do_rst);
    cyc_t c;
    bit stale, rf, rs, redir;
    logic [31:0] tgt;
    @(negedge clk);
    #1;
    if (do_rst) begin
      rst_n = 1'b0;
      m_st = 0;
      m_pc = '0;
      m_ep = 1'b0;
      fq.delete();
    end else begin
      rst_n = 1'b1;
    end
    pc_ready   = pct(p_rdy);
    inst_ready = pct(p_inst);
    resp_valid = (fq.size() != 0) && pct(p_resp);
    if (fq.size() != 0) begin
      resp_inst  = fq[0].inst;
      resp_pc    = fq[0].pc;
      resp_epoch = fq[0].ep;
    end else begin
      resp_inst  = $urandom;
      resp_pc    = $urandom;
      resp_epoch = 1'($urandom);
    end
    alu_valid  = f_alu | pct(p_alu);
    alu_jump   = f_alu | ($urandom_range(0, 3) != 0);
    alu_addr   = f_alu ? f_alu_a : rnd_addr();
    jal_valid  = f_jal | pct(p_jal);
    jal_addr   = f_jal ? f_jal_a : rnd_addr();
    trap_valid = f_trap | pct(p_trap);
    c.pv  = (m_st == 1) && (fq.size() < MAXO);
    c.pc  = m_pc;
    c.ep  = m_ep;
    c.fl  = (m_st == 2);
    c.rdy = (m_st != 0);
    stale = resp_valid && (resp_epoch != m_ep);
    c.rr  = inst_ready | stale;
    c.cnt = fq.size();
    cyc_q.push_back(c);
    if (!do_rst) begin
      rf = c.pv && pc_ready;
      rs = resp_valid && c.rr;
      if (rs && !stale) inst_q.push_back(fq[0]);
      redir = 1'b0;
      tgt   = '0;
      if (c.rdy) begin
`ifdef INTIRVX_FETCH_TRAP_EN
        if (trap_valid) begin
          redir = 1'b1;
          tgt = TVEC;
        end else
`endif
        if (alu_valid && alu_jump) begin
          redir = 1'b1;
          tgt = alu_addr;
        end else if (jal_valid) begin
          redir = 1'b1;
          tgt = jal_addr;
        end
      end
      if (rs) void'(fq.pop_front());
      if (rf) fq.push_back('{$urandom, m_pc, m_ep});
      if (m_st == 0) begin
        m_st = 1;
        m_pc = START_PC;
      end else if (redir) begin
        m_st = 2;
        m_pc = tgt;
        m_ep = ~m_ep;
      end else begin
        m_st = 1;
        if (rf) m_pc = m_pc + STEP;
      end
    end
    f_alu  = 0;
    f_jal  = 0;
    f_trap = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic knobs(input int r, input int rp,
                       input int ir, input int a,
                       input int j);
    p_rdy = r; p_resp = rp; p_inst = ir;
    p_alu = a; p_jal = j;
  endtask

  // monitor: pops one expectation per cycle
  initial begin
    cyc_t c;
    fet_t e;
    forever begin
      @(negedge clk);
      #3;
      if (cyc_q.size() != 0) begin
        c = cyc_q.pop_front();
        chk("pc_valid", pc_valid, c.pv);
        chk("pc", pc, c.pc);
        chk("pc_epoch", pc_epoch, c.ep);
        chk("flush", flush, c.fl);
        chk("alu_ready", alu_ready, c.rdy);
        chk("jal_ready", jal_ready, c.rdy);
`ifdef INTIRVX_FETCH_TRAP_EN
        chk("trap_ready", trap_ready, c.rdy);
`endif
        chk("resp_ready", resp_ready, c.rr);
        chk("outstanding", outstanding, c.cnt);
        chk("inst_take", inst_valid & inst_ready,
            inst_q.size() != 0);
        if (inst_q.size() != 0) begin
          e = inst_q.pop_front();
          if (inst_valid && inst_ready) begin
            chk("inst", inst, e.inst);
            chk("inst_pc", inst_pc, e.pc);
          end
        end
      end
    end
  end

  initial begin
    step(1'b1);
    step(1'b1);
    // fill to the limit with no responses
    knobs(100, 0, 0, 0, 0);
    run(8);
    // steady stream
    knobs(100, 100, 100, 0, 0);
    run(10);
    // ALU jump with entries in flight
    knobs(100, 0, 0, 0, 0);
    f_alu = 1; f_alu_a = 32'h2000;
    step(1'b0);
    knobs(0, 100, 100, 0, 0);
    run(8);
    // ALU and JAL together
    knobs(100, 50, 100, 0, 0);
    f_alu = 1; f_alu_a = 32'h40;
    f_jal = 1; f_jal_a = 32'h80;
    step(1'b0);
    run(6);
    // JAL while stalled on a full counter
    knobs(100, 0, 0, 0, 0);
    run(8);
    f_jal = 1; f_jal_a = 32'h300;
    step(1'b0);
    run(3);
    knobs(100, 100, 100, 0, 0);
    run(6);
    // sequential wrap past the top of memory
    knobs(100, 0, 100, 0, 0);
    f_alu = 1; f_alu_a = 32'hFFFF_FFF8;
    step(1'b0);
    run(5);
    knobs(100, 100, 100, 0, 0);
    run(6);
`ifdef INTIRVX_FETCH_TRAP_EN
    f_trap = 1;
    f_alu = 1; f_alu_a = 32'h4000;
    step(1'b0);
    run(4);
`endif
    // reset in the middle of traffic
    knobs(100, 30, 50, 0, 0);
    run(5);
    step(1'b1);
    run(6);
    // random traffic
    for (int b = 0; b < 20; b++) begin
      knobs($urandom_range(20, 100),
            $urandom_range(10, 100),
            $urandom_range(10, 100),
            $urandom_range(0, 15),
            $urandom_range(0, 15));
`ifdef INTIRVX_FETCH_TRAP_EN
      p_trap = $urandom_range(0, 5);
`endif
      run(100);
    end
    knobs(0, 0, 0, 0, 0);
    p_trap = 0;
    run(2);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
